qar_can_rx_fifo: RTL and testbench
==================================

# qar_can_rx_fifo

Receive-side frame buffer between the CAN protocol engine and the QAR-Core MMIO bus. Each completed frame (ID, IDE, DLC, 8 data bytes) from the engine is pushed into a DEPTH-entry FIFO. Firmware reads the head frame through a zero-wait register window, then pops it. Overflow is flagged when the engine delivers a frame into a full FIFO; the engine has no backpressure, so that frame is dropped.

## Interface
- DEPTH, 4, frame slots; power of two, 2..16
- CNT_W, $clog2(DEPTH+1), occupancy counter width
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  single-cycle strobe: frame complete and CRC-good
- rx_id  in  29  identifier; standard IDs right-aligned in [10:0]
- rx_ide  in  1  1 = extended identifier
- rx_dlc  in  4  data length code, stored verbatim
- rx_data  in  64  byte0 in [63:56] … byte7 in [7:0]
- reg_valid  in  1  bus access request
- reg_we  in  1  1 = write
- reg_addr  in  5  byte offset; [4:2] selects the word
- reg_wdata  in  32  write data
- reg_ready  out  1  equals reg_valid (combinational, zero wait)
- reg_rdata  out  32  read data, combinational
- irq  out  1  level interrupt: irq_en & !empty

## Operation
- Register map (word offsets):
  - 0x00 STATUS (read): [0] !empty, [1] full, [2] overflow, [CNT_W+7:8] count, [23:16] drop_cnt.
  - 0x00 CTRL (write): [0] pop, [1] clear overflow and drop_cnt, [2] irq_en. irq_en holds the written value.
  - 0x04 ID (read): [28:0] id, [29] ide.
  - 0x08 DLC (read): [3:0] dlc.
  - 0x0C DATA0 (read): rx_data[63:32].
  - 0x10 DATA1 (read): rx_data[31:0].
- Reads of 0x04–0x10 return the head slot. They return 0 when the FIFO is empty.
- Unmapped reads return 0. Writes to any offset other than 0x00 are ignored.
- Reads have no side effects. A pop happens only on an explicit CTRL write.
- Push: rx_valid while not full writes the tail slot and increments wr_ptr.
- Push into full: the frame is dropped, overflow is set (sticky), and drop_cnt increments. drop_cnt saturates at 0xFF.
- Pop: CTRL write with bit0=1 while not empty increments rd_ptr. Pop while empty is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately as 0..DEPTH.
- Simultaneous push and pop:
  - Not empty and not full: both happen; count is unchanged.
  - Full: the pop frees a slot and the push is accepted, so no overflow occurs.
  - Empty: the pop is ignored, the push is accepted, and count becomes 1.
- Simultaneous clear (bit1) and overflowing push: the clear wins, so overflow=0 and drop_cnt=0.

## Timing
- Reset values:
  - Pointers, count, overflow, drop_cnt and irq_en are 0.
  - irq=0.
  - reg_rdata=0 when reg_valid=0.
  - Frame storage is not reset.
- A push at edge N is visible in STATUS and the head registers from cycle N+1.
- A pop write at edge N exposes the next frame from cycle N+1.
- irq follows from registered state, with 1-cycle latency after the push, pop or irq_en write.
- Asserting rst_n mid-operation flushes the FIFO immediately. An rx_valid during reset is lost.
- There is no combinational path from rx_* to reg_rdata.

## Structure
- qar_can_pkg holds:
  - the register offset localparams (STATUS/CTRL, ID, DLC, DATA0, DATA1);
  - the STATUS/CTRL bit positions;
  - the frame record width (29+1+4+64 = 98).
- Sub-module qar_can_frame_fifo: a generic DEPTH×98 synchronous FIFO with push/pop/full/empty/count.
- The top level adds the register decode, the overflow/drop logic and irq.

## Test plan
- Push one frame (id=0x123, ide=0, dlc=8, data=0xDEADBEEF_00000000):
  - ID reads 0x123, DATA0 reads 0xDEADBEEF, DATA1 reads 0x0, STATUS[0]=1 and count=1.
  - After a CTRL pop, STATUS reads 0 and the head registers read 0.
- Push 0x123/DEADBEEF_00000000, then 0x321/CAFEBABE_01020304:
  - Reads return them in FIFO order, matching the loopback demo values.
- Push DEPTH+2 frames without popping:
  - full=1, overflow=1, drop_cnt=2.
  - The head is the first frame.
  - CTRL bit1 clears overflow and drop_cnt while count stays DEPTH.
- Fill to full, then drive rx_valid in the same cycle as a pop write:
  - count stays DEPTH and overflow stays 0.
  - The last-pushed frame appears after DEPTH pops.
- Empty FIFO, push and pop in the same cycle: count=1 and the frame is intact.
- irq and reset:
  - Write irq_en=1 and push a frame: irq rises the next cycle and falls the cycle after the final pop.
  - Drop rst_n mid-stream: all outputs read 0.

Source files
------------

// File: rtl/qar_can_pkg.sv
// Shared constants for the CAN receive buffer.
// Register offsets, STATUS/CTRL bit positions and the frame record.
package qar_can_pkg;

  localparam int FRAME_W = 29 + 1 + 4 + 64;

  localparam logic [4:0] REG_STATUS = 5'h00;
  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_ID     = 5'h04;
  localparam logic [4:0] REG_DLC    = 5'h08;
  localparam logic [4:0] REG_DATA0  = 5'h0C;
  localparam logic [4:0] REG_DATA1  = 5'h10;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT    = 8;
  localparam int ST_DROP   = 16;

  localparam int CTRL_POP   = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IRQEN = 2;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

endpackage

// File: rtl/qar_can_frame_fifo.sv
// Generic DEPTH x W synchronous FIFO; storage is not reset.
// push_i/wdata_i in, pop_i in, rdata_o head, full_o/empty_o/count_o.
module qar_can_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 98,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/qar_can_rx_fifo.sv
// CAN receive frame buffer with a zero-wait MMIO register window.
// rx_* frame strobe in; reg_* bus; irq = irq_en & !empty.
module qar_can_rx_fifo
  import qar_can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [28:0] rx_id,
  input  logic        rx_ide,
  input  logic [3:0]  rx_dlc,
  input  logic [63:0] rx_data,
  input  logic        reg_valid,
  input  logic        reg_we,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic        reg_ready,
  output logic [31:0] reg_rdata,
  output logic        irq
);

  frame_t           rx_f, head;
  logic             full, empty;
  logic [CNT_W-1:0] count;
  logic [2:0]       wsel;
  logic             ctrl_wr, pop_req, clr, drop;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic             irq_en_q, irq_en_d;
  logic [31:0]      st;
  logic             unused;

  assign rx_f = '{id: rx_id, ide: rx_ide, dlc: rx_dlc, data: rx_data};

  qar_can_frame_fifo #(
    .DEPTH (DEPTH),
    .W     (FRAME_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_valid),
    .wdata_i (rx_f),
    .pop_i   (pop_req),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign wsel    = reg_addr[4:2];
  assign ctrl_wr = reg_valid & reg_we & (wsel == REG_CTRL[4:2]);
  assign pop_req = ctrl_wr & reg_wdata[CTRL_POP];
  assign clr     = ctrl_wr & reg_wdata[CTRL_CLR];
  // Full implies non-empty, so a same-cycle pop always makes room.
  assign drop    = rx_valid & full & ~pop_req;

  always_comb begin
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    irq_en_d = irq_en_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
    if (clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (ctrl_wr) irq_en_d = reg_wdata[CTRL_IRQEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      irq_en_q <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    st                 = '0;
    st[ST_NEMPTY]      = ~empty;
    st[ST_FULL]        = full;
    st[ST_OVF]         = ovf_q;
    st[ST_CNT +: CNT_W] = count;
    st[ST_DROP +: 8]   = drop_q;
  end

  // Head storage is unreset, so head words are masked when empty.
  always_comb begin
    reg_rdata = '0;
    if (reg_valid && !reg_we) begin
      unique case (1'b1)
        (wsel == REG_STATUS[4:2]):
          reg_rdata = st;
        (wsel == REG_ID[4:2]):
          reg_rdata = empty ? '0 : {2'b0, head.ide, head.id};
        (wsel == REG_DLC[4:2]):
          reg_rdata = empty ? '0 : {28'b0, head.dlc};
        (wsel == REG_DATA0[4:2]):
          reg_rdata = empty ? '0 : head.data[63:32];
        (wsel == REG_DATA1[4:2]):
          reg_rdata = empty ? '0 : head.data[31:0];
        default:
          reg_rdata = '0;
      endcase
    end
  end

  assign reg_ready = reg_valid;
  assign irq       = irq_en_q & ~empty;
  assign unused    = ^{reg_addr[1:0], reg_wdata[31:3]};

endmodule

// File: tb/tb_qar_can_rx_fifo.sv
// Directed + random bench for qar_can_rx_fifo against a queue model.
// Checks STATUS, head window, irq and reset behaviour.
module tb_qar_can_rx_fifo;
  import qar_can_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        reg_valid;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  frame_t m_q[$];
  bit     m_ovf;
  int     m_drop;
  bit     m_irq_en;

  qar_can_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_id     (rx_id),
    .rx_ide    (rx_ide),
    .rx_dlc    (rx_dlc),
    .rx_data   (rx_data),
    .reg_valid (reg_valid),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ready (reg_ready),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    reg_valid = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = a;
    #1;
    d = reg_rdata;
    reg_valid = 1'b0;
    #1;
  endtask

  function automatic frame_t mk(input logic [28:0] id, input logic ide,
                                input logic [3:0] dlc,
                                input logic [63:0] data);
    frame_t f;
    f.id = id; f.ide = ide; f.dlc = dlc; f.data = data;
    return f;
  endfunction

  function automatic frame_t rnd_frame();
    logic [31:0] r;
    frame_t f;
    r = $urandom;
    f.id   = r[28:0];
    f.ide  = r[29];
    f.dlc  = r[3:0] ^ r[31:28];
    f.data = {$urandom, $urandom};
    return f;
  endfunction

  // One clock edge with optional frame strobe and optional CTRL write,
  // then the model applies the same event by the documented rules.
  task automatic cyc(input bit push, input frame_t f, input bit ctrl,
                     input logic [31:0] wd);
    rx_valid  = push;
    rx_id     = f.id;
    rx_ide    = f.ide;
    rx_dlc    = f.dlc;
    rx_data   = f.data;
    reg_valid = ctrl;
    reg_we    = ctrl;
    reg_addr  = 5'h00;
    reg_wdata = wd;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    reg_valid = 1'b0;
    reg_we    = 1'b0;
    if (ctrl && wd[0] && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(f);
      else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
    if (ctrl && wd[1]) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (ctrl) m_irq_en = wd[2];
  endtask

  task automatic push(input frame_t f);
    cyc(1'b1, f, 1'b0, 32'h0);
  endtask

  task automatic ctrl(input logic [31:0] wd);
    cyc(1'b0, '0, 1'b1, wd);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d, e;
    int n;
    n = m_q.size();
    e = 32'(n != 0) | (32'(n == DEPTH) << 1) | (32'(m_ovf) << 2) |
        (32'(n) << 8) | (32'(m_drop) << 16);
    rd(REG_STATUS, d); chk({tag, ".status"}, d, e);
    e = (n == 0) ? 32'h0 : {2'b0, m_q[0].ide, m_q[0].id};
    rd(REG_ID, d); chk({tag, ".id"}, d, e);
    e = (n == 0) ? 32'h0 : {28'b0, m_q[0].dlc};
    rd(REG_DLC, d); chk({tag, ".dlc"}, d, e);
    e = (n == 0) ? 32'h0 : m_q[0].data[63:32];
    rd(REG_DATA0, d); chk({tag, ".data0"}, d, e);
    e = (n == 0) ? 32'h0 : m_q[0].data[31:0];
    rd(REG_DATA1, d); chk({tag, ".data1"}, d, e);
    chk({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq_en && n != 0});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_drop   = 0;
    m_irq_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    frame_t fa, fb, last;

    rst_n = 1'b0; rx_valid = 1'b0; rx_id = '0; rx_ide = 1'b0;
    rx_dlc = '0; rx_data = '0; reg_valid = 1'b0; reg_we = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.irq", {31'b0, irq}, 32'h0);
    chk("rst.rdata_idle", reg_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    check_all("rst");

    fa = mk(29'h123, 1'b0, 4'd8, 64'hDEADBEEF_00000000);
    fb = mk(29'h321, 1'b0, 4'd8, 64'hCAFEBABE_01020304);

    push(fa);
    rd(REG_ID, d);    chk("one.id_const", d, 32'h123);
    rd(REG_DATA0, d); chk("one.d0_const", d, 32'hDEADBEEF);
    rd(REG_DATA1, d); chk("one.d1_const", d, 32'h0);
    rd(REG_STATUS, d); chk("one.st_const", d, 32'h0000_0101);
    reg_valid = 1'b1; #1;
    chk("one.ready", {31'b0, reg_ready}, 32'h1);
    reg_valid = 1'b0; #1;
    check_all("one");
    ctrl(32'h1);
    rd(REG_STATUS, d); chk("one.pop_st", d, 32'h0);
    check_all("one.pop");

    push(fa); push(fb);
    check_all("two.a");
    rd(REG_DATA1, d); chk("two.a_d1", d, 32'h0);
    ctrl(32'h1);
    rd(REG_DATA0, d); chk("two.b_d0", d, 32'hCAFEBABE);
    check_all("two.b");
    ctrl(32'h1);
    check_all("two.empty");

    for (int i = 0; i < DEPTH + 2; i++) push(rnd_frame());
    check_all("ovf");
    rd(REG_STATUS, d);
    chk("ovf.drop2", d[23:16], 32'd2);
    chk("ovf.flags", {29'b0, d[2:0]}, 32'h7);
    ctrl(32'h2);
    check_all("ovf.clr");
    rd(REG_STATUS, d); chk("ovf.cnt_kept", d[15:8], 32'(DEPTH));

    last = rnd_frame();
    cyc(1'b1, last, 1'b1, 32'h1);
    check_all("fullpp");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        rd(REG_DATA1, d); chk("fullpp.last", d, last.data[31:0]);
      end
      ctrl(32'h1);
      check_all("fullpp.pop");
    end

    fa = rnd_frame();
    cyc(1'b1, fa, 1'b1, 32'h1);
    check_all("emptypp");
    ctrl(32'h1);

    ctrl(32'h4);
    check_all("irq.en");
    push(rnd_frame());
    chk("irq.rise", {31'b0, irq}, 32'h1);
    push(rnd_frame());
    ctrl(32'h5);
    chk("irq.hold", {31'b0, irq}, 32'h1);
    ctrl(32'h5);
    chk("irq.fall", {31'b0, irq}, 32'h0);
    check_all("irq");

    for (int i = 0; i < DEPTH + 260; i++) push(rnd_frame());
    rd(REG_STATUS, d); chk("sat.drop", d[23:16], 32'hFF);
    check_all("sat");
    cyc(1'b1, rnd_frame(), 1'b1, 32'h2);
    check_all("sat.clrwin");

    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = REG_ID; reg_wdata = 32'h3;
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_we = 1'b0;
    check_all("wr_other");
    rd(5'h14, d); chk("unmapped14", d, 32'h0);
    rd(5'h1C, d); chk("unmapped1c", d, 32'h0);

    for (int i = 0; i < DEPTH; i++) ctrl(32'h1);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r, wd;
      r  = $urandom;
      wd = {29'b0, r[10], (r[9:6] == 4'd0), r[5]};
      cyc(r[0] | r[1], rnd_frame(), r[2] & r[3] | r[4], wd);
      check_all("rnd");
    end

    ctrl(32'h4);
    push(rnd_frame()); push(rnd_frame());
    rx_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst.irq", {31'b0, irq}, 32'h0);
    chk("mrst.rdata_idle", reg_rdata, 32'h0);
    rd(REG_STATUS, d); chk("mrst.status", d, 32'h0);
    rd(REG_ID, d); chk("mrst.id", d, 32'h0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all("mrst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
